// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the shared-ALU arbiter slice.
// Contents:
//   - aluOp encodings seen on the requester side
//   - R-type funct codes understood by the ALU
//   - 4-bit ALU control codes driven into the execute datapath
//   - FSM state encoding for the arbiter
//   - alu_decode(): maps (aluOp, funct) to an ALU control code plus error flags
package alu_pkg;

  // aluOp field carried with every request
  localparam logic [1:0] ALU_OP_ADD   = 2'd0;
  localparam logic [1:0] ALU_OP_AND   = 2'd1;
  localparam logic [1:0] ALU_OP_RTYPE = 2'd2;
  localparam logic [1:0] ALU_OP_RSVD  = 2'd3;

  // funct codes recognised when aluOp selects R-type
  localparam logic [5:0] FUNCT_SLL = 6'd0;
  localparam logic [5:0] FUNCT_SRL = 6'd2;
  localparam logic [5:0] FUNCT_SRA = 6'd3;
  localparam logic [5:0] FUNCT_ADD = 6'd32;
  localparam logic [5:0] FUNCT_SUB = 6'd34;
  localparam logic [5:0] FUNCT_AND = 6'd36;
  localparam logic [5:0] FUNCT_OR  = 6'd37;
  localparam logic [5:0] FUNCT_SLT = 6'd42;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_SLL = 4'd4,
    ALU_SRL = 4'd5,
    ALU_SRA = 4'd6,
    ALU_SLT = 4'd7
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    alu_ctrl_e ctrl;
    logic      force_zero;
    logic      err;
  } alu_decode_t;

  // Unknown funct still runs an ADD so the consumer gets a defined value,
  // while the reserved aluOp forces a zero result; both raise err.
  function automatic alu_decode_t alu_decode(input logic [1:0] op, input logic [5:0] funct);
    alu_decode_t d;
    d.ctrl       = ALU_ADD;
    d.force_zero = 1'b0;
    d.err        = 1'b0;
    case (op)
      ALU_OP_ADD: d.ctrl = ALU_ADD;
      ALU_OP_AND: d.ctrl = ALU_AND;
      ALU_OP_RTYPE: begin
        case (funct)
          FUNCT_SLL: d.ctrl = ALU_SLL;
          FUNCT_SRL: d.ctrl = ALU_SRL;
          FUNCT_SRA: d.ctrl = ALU_SRA;
          FUNCT_ADD: d.ctrl = ALU_ADD;
          FUNCT_SUB: d.ctrl = ALU_SUB;
          FUNCT_AND: d.ctrl = ALU_AND;
          FUNCT_OR:  d.ctrl = ALU_OR;
          FUNCT_SLT: d.ctrl = ALU_SLT;
          default: begin
            d.ctrl = ALU_ADD;
            d.err  = 1'b1;
          end
        endcase
      end
      default: begin
        d.force_zero = 1'b1;
        d.err        = 1'b1;
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if
// Request/response bundle between the requesting pipeline stages (master)
// and the shared-ALU arbiter (slave).
// Signals:
//   req_valid   [NUM_REQ]     per-requester request strobe
//   req_ready   [NUM_REQ]     one-hot grant from the arbiter
//   req_alu_op  [2*NUM_REQ]   per-requester aluOp
//   req_funct   [6*NUM_REQ]   per-requester funct field
//   req_a/b     [32*NUM_REQ]  per-requester operands
//   resp_valid  result available
//   resp_ready  consumer accepts result
//   resp_result 32-bit ALU result
//   resp_id     [ID_W] owner of resp_result
//   resp_err    illegal aluOp or funct
interface alu_share_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [2*NUM_REQ-1:0]  req_alu_op;
  logic [6*NUM_REQ-1:0]  req_funct;
  logic [32*NUM_REQ-1:0] req_a;
  logic [32*NUM_REQ-1:0] req_b;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [31:0]           resp_result;
  logic [ID_W-1:0]       resp_id;
  logic                  resp_err;

  modport master (
    output req_valid, req_alu_op, req_funct, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_result, resp_id, resp_err
  );

  modport slave (
    input  req_valid, req_alu_op, req_funct, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_result, resp_id, resp_err
  );
endinterface

// File: rtl/alu_exec_unit.sv
// alu_exec_unit
// Purely combinational decode plus 32-bit integer datapath.
// Ports:
//   op     in  2   aluOp of the captured request
//   funct  in  6   funct field of the captured request
//   a      in  32  operand A (signed); A[4:0] is also the shift amount
//   b      in  32  operand B (signed); the value that gets shifted
//   result out 32  ALU result (ADD/SUB wrap mod 2^32)
//   err    out 1   illegal aluOp or funct
module alu_exec_unit
  import alu_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [5:0]  funct,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        err
);

  alu_decode_t dec;
  logic [31:0] raw;

  always_comb begin
    dec = alu_decode(op, funct);
    raw = a + b;
    case (dec.ctrl)
      ALU_ADD: raw = a + b;
      ALU_SUB: raw = a - b;
      ALU_AND: raw = a & b;
      ALU_OR:  raw = a | b;
      ALU_SLL: raw = b << a[4:0];
      ALU_SRL: raw = b >> a[4:0];
      // Shifts move B by A; SRA keeps B's sign bit.
      ALU_SRA: raw = $signed(b) >>> a[4:0];
      ALU_SLT: raw = {31'd0, ($signed(a) < $signed(b))};
      default: raw = a + b;
    endcase
    result = dec.force_zero ? 32'd0 : raw;
    err    = dec.err;
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Shares one 32-bit ALU among NUM_REQ requesters with a round-robin grant,
// operand capture, a one-cycle execute and a registered response that is held
// until the consumer accepts it.
// Ports:
//   clock  in   rising-edge clock
//   reset  in   synchronous, active-high reset
//   bus    slave modport of alu_share_arbiter_if (requests and response)
//   busy   out  high while an op is executing or its response is pending
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic               clock,
  input  logic               reset,
  alu_share_arbiter_if.slave bus,
  output logic               busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e state;
  state_e state_next;

  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   grant_idx;
  logic               grant_found;
  logic               accept_window;
  logic               accept;
  logic [NUM_REQ-1:0] grant_onehot;

  logic [1:0]         cap_op;
  logic [5:0]         cap_funct;
  logic [31:0]        cap_a;
  logic [31:0]        cap_b;
  logic [PTR_W-1:0]   cap_id;

  logic [31:0]        exec_result;
  logic               exec_err;

  logic               resp_valid_q;
  logic [31:0]        resp_result_q;
  logic [ID_W-1:0]    resp_id_q;
  logic               resp_err_q;

  // Round-robin search: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    int idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!grant_found && bus.req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = PTR_W'(idx);
      end
    end
  end

  // A new op may be taken when idle, or in the same cycle the pending
  // response is retired, which gives back-to-back ops every 2 cycles.
  assign accept_window = (state == ST_IDLE) || ((state == ST_RESP) && bus.resp_ready);
  assign accept        = accept_window && grant_found;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: state_next = ST_RESP;
      ST_RESP: begin
        if (bus.resp_ready) begin
          state_next = accept ? ST_EXEC : ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    grant_onehot = '0;
    if (accept) begin
      grant_onehot[grant_idx] = 1'b1;
    end
    busy = (state == ST_EXEC) || (state == ST_RESP);
  end

  assign bus.req_ready = grant_onehot;

  alu_exec_unit u_exec (
    .op     (cap_op),
    .funct  (cap_funct),
    .a      (cap_a),
    .b      (cap_b),
    .result (exec_result),
    .err    (exec_err)
  );

  // Capture on accept so requesters only need valid operands in the grant
  // cycle; the response registers load from the ALU during EXEC. A reset in
  // EXEC drops the op because resp_valid is never set.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr        <= '0;
      cap_op        <= '0;
      cap_funct     <= '0;
      cap_a         <= '0;
      cap_b         <= '0;
      cap_id        <= '0;
      resp_valid_q  <= 1'b0;
      resp_result_q <= '0;
      resp_id_q     <= '0;
      resp_err_q    <= 1'b0;
    end else begin
      if (accept) begin
        cap_op    <= bus.req_alu_op[grant_idx*2 +: 2];
        cap_funct <= bus.req_funct[grant_idx*6 +: 6];
        cap_a     <= bus.req_a[grant_idx*32 +: 32];
        cap_b     <= bus.req_b[grant_idx*32 +: 32];
        cap_id    <= grant_idx;
        rr_ptr    <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
      end
      if (state == ST_EXEC) begin
        resp_valid_q  <= 1'b1;
        resp_result_q <= exec_result;
        resp_id_q     <= ID_W'(cap_id);
        resp_err_q    <= exec_err;
      end else if ((state == ST_RESP) && bus.resp_ready) begin
        resp_valid_q <= 1'b0;
      end
    end
  end

  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_result = resp_result_q;
  assign bus.resp_id     = resp_id_q;
  assign bus.resp_err    = resp_err_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter
// Self-checking bench for alu_share_arbiter with NUM_REQ=2.
// A cycle-level behavioural model (pending op, held response, pointer)
// predicts grants and responses and is compared on every falling edge;
// directed sequences add hand-computed literal expectations.
module tb_alu_share_arbiter;

  localparam int NUM_REQ = 2;
  localparam int ID_W    = 1;

  logic clock;
  logic reset;
  logic busy;

  int tests_run;
  int tests_failed;
  int cycle;

  int          grant_log[$];
  int          grant_cyc[$];
  logic [31:0] resp_log[$];

  alu_share_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  alu_share_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Reference ALU written directly from the opcode table.
  function automatic void ref_alu(input logic [1:0] op, input logic [5:0] fn,
                                  input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic e);
    r = 32'd0;
    e = 1'b0;
    if (op == 2'd0) r = a + b;
    else if (op == 2'd1) r = a & b;
    else if (op == 2'd3) begin r = 32'd0; e = 1'b1; end
    else begin
      case (fn)
        6'd0:  r = b << a[4:0];
        6'd2:  r = b >> a[4:0];
        6'd3:  r = 32'($signed(b) >>> a[4:0]);
        6'd32: r = a + b;
        6'd34: r = a - b;
        6'd36: r = a & b;
        6'd37: r = a | b;
        6'd42: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        default: begin r = a + b; e = 1'b1; end
      endcase
    end
  endfunction

  // Behavioural model and per-cycle compare.
  logic        m_exec;
  logic        m_hold;
  int          m_ptr;
  logic [1:0]  m_op;
  logic [5:0]  m_fn;
  logic [31:0] m_a;
  logic [31:0] m_b;
  int          m_cap_id;
  logic [31:0] m_res;
  logic        m_err;
  int          m_id;

  always @(negedge clock) begin : model
    int                 g;
    int                 k;
    logic               window;
    logic [NUM_REQ-1:0] exp_ready;
    if (reset) begin
      m_exec = 1'b0;
      m_hold = 1'b0;
      m_ptr  = 0;
      m_res  = 32'd0;
      m_err  = 1'b0;
      m_id   = 0;
    end else begin
      window = !m_exec && (!m_hold || bus.resp_ready);
      g = -1;
      if (window) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          k = (m_ptr + i) % NUM_REQ;
          if (g < 0 && bus.req_valid[k]) g = k;
        end
      end
      exp_ready = '0;
      if (g >= 0) exp_ready[g] = 1'b1;
      check_output("model_req_ready", 32'(bus.req_ready), 32'(exp_ready));
      check_output("model_busy", 32'(busy), 32'(m_exec || m_hold));
      check_output("model_resp_valid", 32'(bus.resp_valid), 32'(m_hold));
      check_output("model_resp_result", bus.resp_result, m_res);
      if (m_hold) begin
        check_output("model_resp_id", 32'(bus.resp_id), 32'(m_id));
        check_output("model_resp_err", 32'(bus.resp_err), 32'(m_err));
      end
      if (m_hold && bus.resp_ready) begin
        m_hold = 1'b0;
        resp_log.push_back(m_res);
      end
      if (m_exec) begin
        ref_alu(m_op, m_fn, m_a, m_b, m_res, m_err);
        m_id   = m_cap_id;
        m_hold = 1'b1;
        m_exec = 1'b0;
      end
      if (g >= 0) begin
        m_op     = bus.req_alu_op[g*2 +: 2];
        m_fn     = bus.req_funct[g*6 +: 6];
        m_a      = bus.req_a[g*32 +: 32];
        m_b      = bus.req_b[g*32 +: 32];
        m_cap_id = g;
        m_exec   = 1'b1;
        m_ptr    = (g + 1) % NUM_REQ;
        grant_log.push_back(g);
        grant_cyc.push_back(cycle);
      end
    end
    cycle++;
  end

  task automatic set_req(input int r, input logic v, input logic [1:0] op, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b);
    bus.req_valid[r]         = v;
    bus.req_alu_op[r*2 +: 2] = op;
    bus.req_funct[r*6 +: 6]  = fn;
    bus.req_a[r*32 +: 32]    = a;
    bus.req_b[r*32 +: 32]    = b;
  endtask

  task automatic apply_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // Issue one op on requester r alone, check T+1/T+2 timing and the literal result.
  task automatic apply_stimulus(input string name, input int r, input logic [1:0] op, input logic [5:0] fn,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] exp_result, input logic exp_err);
    int waited;
    @(posedge clock); #1;
    bus.resp_ready = 1'b0;
    set_req(r, 1'b1, op, fn, a, b);
    waited = 0;
    @(negedge clock);
    while (!bus.req_ready[r] && waited < 20) begin
      @(posedge clock); #1;
      @(negedge clock);
      waited++;
    end
    check_output({name, "_grant"}, 32'(bus.req_ready[r]), 32'd1);
    if (!bus.req_ready[r]) begin
      set_req(r, 1'b0, 2'd0, 6'd0, 32'd0, 32'd0);
      return;
    end
    @(posedge clock); #1;
    set_req(r, 1'b0, 2'd3, 6'h3F, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    @(negedge clock);
    check_output({name, "_valid_t1"}, 32'(bus.resp_valid), 32'd0);
    @(posedge clock); #1;
    @(negedge clock);
    check_output({name, "_valid_t2"}, 32'(bus.resp_valid), 32'd1);
    check_output({name, "_result"}, bus.resp_result, exp_result);
    check_output({name, "_id"}, 32'(bus.resp_id), 32'(r));
    check_output({name, "_err"}, 32'(bus.resp_err), 32'(exp_err));
    @(posedge clock); #1;
    bus.resp_ready = 1'b1;
    @(posedge clock); #1;
    bus.resp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tests_run      = 0;
    tests_failed   = 0;
    cycle          = 0;
    reset          = 1'b1;
    bus.req_valid  = '0;
    bus.req_alu_op = '0;
    bus.req_funct  = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;

    // Reset state
    @(negedge clock);
    check_output("reset_resp_valid", 32'(bus.resp_valid), 32'd0);
    check_output("reset_resp_result", bus.resp_result, 32'd0);
    check_output("reset_resp_id", 32'(bus.resp_id), 32'd0);
    check_output("reset_resp_err", 32'(bus.resp_err), 32'd0);
    check_output("reset_req_ready", 32'(bus.req_ready), 32'd0);
    check_output("reset_busy", 32'(busy), 32'd0);

    // Single R-type ADD on req0
    apply_stimulus("t1_add", 0, 2'd2, 6'd32, 32'd5, 32'd7, 32'd12, 1'b0);

    // Two requesters continuously valid, consumer always ready
    apply_reset();
    grant_log.delete();
    grant_cyc.delete();
    resp_log.delete();
    bus.resp_ready = 1'b1;
    set_req(0, 1'b1, 2'd0, 6'd0, 32'd10, 32'd20);
    set_req(1, 1'b1, 2'd1, 6'd0, 32'h0000_F0F0, 32'h0000_FF00);
    repeat (12) @(posedge clock);
    #1;
    set_req(0, 1'b0, 2'd0, 6'd0, 32'd0, 32'd0);
    set_req(1, 1'b0, 2'd0, 6'd0, 32'd0, 32'd0);
    repeat (4) @(posedge clock);
    #1;
    bus.resp_ready = 1'b0;
    check_output("t2_grant_count", 32'(grant_log.size() >= 4), 32'd1);
    check_output("t2_resp_count", 32'(resp_log.size() >= 4), 32'd1);
    if (grant_log.size() >= 4 && resp_log.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        check_output($sformatf("t2_grant_%0d", i), 32'(grant_log[i]), 32'(i % 2));
        check_output($sformatf("t2_resp_%0d", i), resp_log[i], (i % 2 == 0) ? 32'd30 : 32'h0000_F000);
      end
      for (int i = 0; i < 3; i++) begin
        check_output($sformatf("t2_spacing_%0d", i), 32'(grant_cyc[i+1] - grant_cyc[i]), 32'd2);
      end
    end

    // SLT and SRA
    apply_stimulus("t3_slt", 0, 2'd2, 6'd42, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0);
    apply_stimulus("t3_sra", 1, 2'd2, 6'd3, 32'd4, 32'h8000_0000, 32'hF800_0000, 1'b0);
    apply_stimulus("t3_sll", 1, 2'd2, 6'd0, 32'd33, 32'd3, 32'd6, 1'b0);
    apply_stimulus("t3_srl", 0, 2'd2, 6'd2, 32'd4, 32'h8000_0000, 32'h0800_0000, 1'b0);
    apply_stimulus("t3_wrap", 0, 2'd0, 6'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
    apply_stimulus("t3_sub", 1, 2'd2, 6'd34, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0);
    apply_stimulus("t3_or", 0, 2'd2, 6'd37, 32'h0F, 32'hF0, 32'hFF, 1'b0);

    // Back-pressure: response held, req1 waits for the retire cycle
    @(posedge clock); #1;
    set_req(0, 1'b1, 2'd0, 6'd0, 32'd100, 32'd23);
    @(negedge clock);
    check_output("t4_grant0", 32'(bus.req_ready), 32'd1);
    @(posedge clock); #1;
    set_req(0, 1'b0, 2'd0, 6'd0, 32'd0, 32'd0);
    set_req(1, 1'b1, 2'd2, 6'd34, 32'd50, 32'd8);
    @(negedge clock);
    check_output("t4_ready_exec", 32'(bus.req_ready), 32'd0);
    @(posedge clock); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check_output($sformatf("t4_hold_valid_%0d", i), 32'(bus.resp_valid), 32'd1);
      check_output($sformatf("t4_hold_result_%0d", i), bus.resp_result, 32'd123);
      check_output($sformatf("t4_hold_ready_%0d", i), 32'(bus.req_ready), 32'd0);
      @(posedge clock); #1;
    end
    bus.resp_ready = 1'b1;
    @(negedge clock);
    check_output("t4_grant1", 32'(bus.req_ready), 32'd2);
    @(posedge clock); #1;
    bus.resp_ready = 1'b0;
    set_req(1, 1'b0, 2'd0, 6'd0, 32'd0, 32'd0);
    @(negedge clock);
    check_output("t4_valid_exec", 32'(bus.resp_valid), 32'd0);
    @(posedge clock); #1;
    @(negedge clock);
    check_output("t4_req1_valid", 32'(bus.resp_valid), 32'd1);
    check_output("t4_req1_result", bus.resp_result, 32'd42);
    check_output("t4_req1_id", 32'(bus.resp_id), 32'd1);
    @(posedge clock); #1;
    bus.resp_ready = 1'b1;
    @(posedge clock); #1;
    bus.resp_ready = 1'b0;

    // Error encodings
    apply_stimulus("t5_rsvd", 0, 2'd3, 6'd0, 32'd7, 32'd9, 32'd0, 1'b1);
    apply_stimulus("t5_badfunct", 0, 2'd2, 6'd63, 32'd2, 32'd3, 32'd5, 1'b1);

    // Reset during EXEC drops the op and clears the pointer
    @(posedge clock); #1;
    set_req(0, 1'b1, 2'd0, 6'd0, 32'd1, 32'd1);
    @(negedge clock);
    check_output("t6_grant0", 32'(bus.req_ready), 32'd1);
    @(posedge clock); #1;
    set_req(0, 1'b0, 2'd0, 6'd0, 32'd0, 32'd0);
    reset = 1'b1;
    @(negedge clock);
    check_output("t6_busy_exec", 32'(busy), 32'd1);
    @(posedge clock); #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check_output($sformatf("t6_no_resp_%0d", i), 32'(bus.resp_valid), 32'd0);
      @(posedge clock); #1;
    end
    set_req(0, 1'b1, 2'd0, 6'd0, 32'd2, 32'd2);
    set_req(1, 1'b1, 2'd0, 6'd0, 32'd3, 32'd3);
    @(negedge clock);
    check_output("t6_grant_after_reset", 32'(bus.req_ready), 32'd1);
    @(posedge clock); #1;
    set_req(0, 1'b0, 2'd0, 6'd0, 32'd0, 32'd0);
    set_req(1, 1'b0, 2'd0, 6'd0, 32'd0, 32'd0);
    bus.resp_ready = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    bus.resp_ready = 1'b0;
    repeat (2) @(posedge clock);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
